// File: rtl/bubble_sort_ctrl_if.sv
// Bus bundle between the bubble sort controller, its host FSM and a 2R/1W RAM
// with asynchronous read.
interface bubble_sort_ctrl_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    // host side
    logic                        start;
    logic [ADDR_WIDTH:0]         len;
    logic                        descending;
    logic                        busy;
    logic                        finish;
    logic [2*ADDR_WIDTH-1:0]     swap_cnt;
    // RAM side
    logic [ADDR_WIDTH-1:0]       read_addr_1;
    logic [ADDR_WIDTH-1:0]       read_addr_2;
    logic [DATA_WIDTH-1:0]       read_data_1;
    logic [DATA_WIDTH-1:0]       read_data_2;
    logic [ADDR_WIDTH-1:0]       write_addr;
    logic [DATA_WIDTH-1:0]       write_data;
    logic                        we;

    // controller view
    modport slave (
        input  start, len, descending, read_data_1, read_data_2,
        output busy, finish, swap_cnt, read_addr_1, read_addr_2,
               write_addr, write_data, we
    );

    // host + RAM view
    modport master (
        output start, len, descending, read_data_1, read_data_2,
        input  busy, finish, swap_cnt, read_addr_1, read_addr_2,
               write_addr, write_data, we
    );
endinterface

// File: rtl/bubble_sort_ctrl.sv
// In-place bubble sort controller for an external RAM with two asynchronous
// read ports and one write port. Supports run-time length, ascending or
// descending order, optional signed compare, early exit on a clean pass and
// a swap counter. All outputs are registered.
module bubble_sort_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int SIGNED     = 0
) (
    input  logic               clk,
    input  logic               reset,
    bubble_sort_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COMPARE = 3'd1,
        S_SWAP1   = 3'd2,
        S_SWAP2   = 3'd3,
        S_ADVANCE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH:0]       MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]       TWO_L   = (ADDR_WIDTH+1)'(32'd2);
    localparam logic [ADDR_WIDTH:0]       ONE_L   = (ADDR_WIDTH+1)'(32'd1);
    localparam logic [ADDR_WIDTH-1:0]     ZERO_A  = '0;
    localparam logic [ADDR_WIDTH-1:0]     ONE_A   = ADDR_WIDTH'(32'd1);
    localparam logic [ADDR_WIDTH-1:0]     TWO_A   = ADDR_WIDTH'(32'd2);
    localparam logic [2*ADDR_WIDTH-1:0]   ONE_C   = (2*ADDR_WIDTH)'(32'd1);

    // Strict greater-than in the configured number representation.
    function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end else begin
            return a > b;
        end
    endfunction

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]    last_q, last_d;
    logic                     swapped_q, swapped_d;
    logic                     desc_q, desc_d;
    logic [DATA_WIDTH-1:0]    d1_q, d1_d;
    logic [ADDR_WIDTH-1:0]    ra1_q, ra1_d;
    logic [ADDR_WIDTH-1:0]    ra2_q, ra2_d;
    logic [ADDR_WIDTH-1:0]    wa_q, wa_d;
    logic [DATA_WIDTH-1:0]    wd_q, wd_d;
    logic                     we_q, we_d;
    logic                     busy_q, busy_d;
    logic                     finish_q, finish_d;
    logic [2*ADDR_WIDTH-1:0]  swap_cnt_q, swap_cnt_d;

    logic [ADDR_WIDTH:0]      len_sat_s;
    logic                     ooo_s;

    // Clamp the requested length to the RAM depth.
    always_comb begin
        len_sat_s = bus.len;
        if (bus.len > MAX_LEN) begin
            len_sat_s = MAX_LEN;
        end else begin
            len_sat_s = bus.len;
        end
    end

    // Out-of-order test on the live pair; equal elements never swap.
    always_comb begin
        ooo_s = desc_q ? gt(bus.read_data_2, bus.read_data_1)
                       : gt(bus.read_data_1, bus.read_data_2);
    end

    // Next-state and next-output logic of the sort FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        swapped_d  = swapped_q;
        desc_d     = desc_q;
        d1_d       = d1_q;
        ra1_d      = ra1_q;
        ra2_d      = ra2_q;
        wa_d       = wa_q;
        wd_d       = wd_q;
        we_d       = 1'b0;
        swap_cnt_d = swap_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    desc_d     = bus.descending;
                    swap_cnt_d = '0;
                    if (len_sat_s < TWO_L) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = ZERO_A;
                        last_d    = ADDR_WIDTH'(len_sat_s - ONE_L);
                        swapped_d = 1'b0;
                        ra1_d     = ZERO_A;
                        ra2_d     = ONE_A;
                        state_d   = S_COMPARE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMPARE: begin
                d1_d = bus.read_data_1;
                if (ooo_s) begin
                    we_d    = 1'b1;
                    wa_d    = idx_q;
                    wd_d    = bus.read_data_2;
                    state_d = S_SWAP1;
                end else begin
                    state_d = S_ADVANCE;
                end
            end
            S_SWAP1: begin
                we_d       = 1'b1;
                wa_d       = idx_q + ONE_A;
                wd_d       = d1_q;
                swapped_d  = 1'b1;
                swap_cnt_d = swap_cnt_q + ONE_C;
                state_d    = S_SWAP2;
            end
            S_SWAP2: begin
                state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                if ((idx_q + ONE_A) < last_q) begin
                    idx_d   = idx_q + ONE_A;
                    ra1_d   = idx_q + ONE_A;
                    ra2_d   = idx_q + TWO_A;
                    state_d = S_COMPARE;
                end else if (!swapped_q || (last_q == ONE_A)) begin
                    state_d = S_DONE;
                end else begin
                    last_d    = last_q - ONE_A;
                    idx_d     = ZERO_A;
                    swapped_d = 1'b0;
                    ra1_d     = ZERO_A;
                    ra2_d     = ONE_A;
                    state_d   = S_COMPARE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        finish_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            swapped_q  <= 1'b0;
            desc_q     <= 1'b0;
            d1_q       <= '0;
            ra1_q      <= '0;
            ra2_q      <= '0;
            wa_q       <= '0;
            wd_q       <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
            swap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            swapped_q  <= swapped_d;
            desc_q     <= desc_d;
            d1_q       <= d1_d;
            ra1_q      <= ra1_d;
            ra2_q      <= ra2_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            finish_q   <= finish_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    assign bus.read_addr_1 = ra1_q;
    assign bus.read_addr_2 = ra2_q;
    assign bus.write_addr  = wa_q;
    assign bus.write_data  = wd_q;
    assign bus.we          = we_q;
    assign bus.busy        = busy_q;
    assign bus.finish      = finish_q;
    assign bus.swap_cnt    = swap_cnt_q;

endmodule
